m1_fetch_sequencer: RTL

// - Drives the M1 opcode-fetch machine cycle (T1,T2,Tw*,T3,T4). Latches the fetched opcode and presents it
//   as Source/notSource with a decode-enable strobe to the per-opcode decoder tree.
// - Consumes the decoder's return strobes: P2_Set_CM1 chains the next M1, Pa_Ophd holds the opcode,
//   PR_Ex_AF_AF swaps the AF bank. Sits between the bus pins and the op decoders; owns R and the AF bank bit.

---
 rtl/m1_pkg.sv | 37 +++
 rtl/m1_refresh_counter.sv | 24 ++
 rtl/m1_fetch_sequencer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/m1_pkg.sv
// Shared types for the M1 opcode-fetch sequencer: one-hot machine-cycle states
// and the bus-strobe pattern each state drives.
package m1_pkg;

  typedef enum logic [6:0] {
    RST  = 7'b000_0001,
    T1   = 7'b000_0010,
    T2   = 7'b000_0100,
    TW   = 7'b000_1000,
    T3   = 7'b001_0000,
    T4   = 7'b010_0000,
    HOLD = 7'b100_0000
  } m1_state_t;

  typedef struct packed {
    logic m1_n;
    logic mreq_n;
    logic rd_n;
    logic rfsh_n;
  } m1_strobes_t;

  localparam m1_strobes_t STB_IDLE    = '{m1_n: 1'b1, mreq_n: 1'b1, rd_n: 1'b1, rfsh_n: 1'b1};
  localparam m1_strobes_t STB_FETCH   = '{m1_n: 1'b0, mreq_n: 1'b0, rd_n: 1'b0, rfsh_n: 1'b1};
  localparam m1_strobes_t STB_REFRESH = '{m1_n: 1'b1, mreq_n: 1'b1, rd_n: 1'b1, rfsh_n: 1'b0};

  function automatic m1_strobes_t strobes_for(input m1_state_t s);
    m1_strobes_t stb;
    stb = STB_IDLE;
    case (s)
      T1, T2, TW: stb = STB_FETCH;
      T3, T4:     stb = STB_REFRESH;
      default:    stb = STB_IDLE;
    endcase
    return stb;
  endfunction

endpackage

// File: rtl/m1_refresh_counter.sv
// Refresh register R: the low R_WIDTH bits count once per completed M1 and
// wrap; the bits above them are never touched by refresh.
module m1_refresh_counter
  import m1_pkg::*;
#(
  parameter int R_WIDTH = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  output logic [7:0] r_reg
);

  localparam logic [R_WIDTH-1:0] R_STEP = {{(R_WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg <= '0;
    end else if (inc) begin
      r_reg <= {r_reg[7:R_WIDTH], r_reg[R_WIDTH-1:0] + R_STEP};
    end
  end

endmodule

// File: rtl/m1_fetch_sequencer.sv
// M1 opcode-fetch sequencer: runs T1/T2/Tw*/T3/T4, latches the opcode for the
// decoder tree and applies the decoder's T4 return strobes. All outputs are registered.
module m1_fetch_sequencer
  import m1_pkg::*;
#(
  parameter logic [15:0] RST_VEC = 16'h0000,
  parameter int          R_WIDTH = 7
) (
  input  logic        CLK,
  input  logic        notRESET,
  input  logic        notWAIT,
  input  logic [7:0]  D,
  input  logic [15:0] PC,
  input  logic [7:0]  I_Reg,
  input  logic        Start_M1,
  input  logic        P2_Set_CM1,
  input  logic        Pa_Ophd,
  input  logic        PR_Ex_AF_AF,
  output logic [15:0] A,
  output logic        notM1,
  output logic        notMREQ,
  output logic        notRD,
  output logic        notRFSH,
  output logic [7:0]  Source,
  output logic [7:0]  notSource,
  output logic        enable,
  output logic        PC_Inc,
  output logic        PC_Load,
  output logic [15:0] PC_Val,
  output logic        AF_Bank,
  output logic [7:0]  R_Reg,
  output logic        Handoff
);

  m1_state_t   state, next_state;
  m1_strobes_t strobes_q, strobes_d;
  logic [15:0] a_d;
  logic [7:0]  source_d;
  logic        enable_d, pc_inc_d, pc_load_d, handoff_d, af_bank_d;
  logic        fetch_done, m1_done;

  assign fetch_done = ((state == T2) || (state == TW)) && notWAIT;
  assign m1_done    = (state == T4);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge notRESET) begin
    if (!notRESET) state <= RST;
    else           state <= next_state;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      RST:     next_state = T1;
      T1:      next_state = T2;
      T2, TW:  next_state = notWAIT ? T3 : TW;
      T3:      next_state = T4;
      T4:      next_state = P2_Set_CM1 ? T1 : HOLD;
      HOLD:    next_state = Start_M1 ? T1 : HOLD;
      default: next_state = RST;
    endcase
  end

  // Outputs are computed for the state being entered, then registered on the same edge.
  always_comb begin
    strobes_d = strobes_for(next_state);
    enable_d  = (next_state == T3) || (next_state == T4);

    a_d = A;
    if ((next_state == T1) || (next_state == HOLD)) a_d = PC;
    else if ((next_state == T3) || (next_state == T4)) a_d = {I_Reg, R_Reg};

    source_d = Source;
    if (fetch_done)                source_d = D;
    else if (m1_done && !Pa_Ophd)  source_d = 8'h00;

    pc_inc_d  = fetch_done;
    pc_load_d = (state == RST);
    handoff_d = m1_done && !P2_Set_CM1;
    // Sampling only on the T4 exit edge gives at most one bank swap per M1.
    af_bank_d = AF_Bank ^ (m1_done && PR_Ex_AF_AF);
  end

  always_ff @(posedge CLK or negedge notRESET) begin
    if (!notRESET) begin
      strobes_q <= STB_IDLE;
      A         <= '0;
      Source    <= 8'h00;
      notSource <= 8'hFF;
      enable    <= 1'b0;
      PC_Inc    <= 1'b0;
      PC_Load   <= 1'b0;
      Handoff   <= 1'b0;
      AF_Bank   <= 1'b0;
    end else begin
      strobes_q <= strobes_d;
      A         <= a_d;
      Source    <= source_d;
      notSource <= ~source_d;
      enable    <= enable_d;
      PC_Inc    <= pc_inc_d;
      PC_Load   <= pc_load_d;
      Handoff   <= handoff_d;
      AF_Bank   <= af_bank_d;
    end
  end

  assign notM1    = strobes_q.m1_n;
  assign notMREQ  = strobes_q.mreq_n;
  assign notRD    = strobes_q.rd_n;
  assign notRFSH  = strobes_q.rfsh_n;
  assign PC_Val   = RST_VEC;

  m1_refresh_counter #(
    .R_WIDTH (R_WIDTH)
  ) u_refresh (
    .clk   (CLK),
    .rst_n (notRESET),
    .inc   (m1_done),
    .r_reg (R_Reg)
  );

endmodule
